// File: rtl/w_writeback_grf.sv
// rtl/w_writeback_grf.sv - W-stage writeback decode plus 32x32 register file
// with write-through bypass on the D-stage read ports.
module w_writeback_grf (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] W_IR,
  input  logic [31:0] W_PC,
  input  logic [31:0] W_DR,
  input  logic [31:0] W_Y,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [4:0]  W_A3,
  output logic [31:0] W_WD,
  output logic        W_WE
);

  logic [31:0] regs [0:31];
  logic        dec_wr;
  logic [4:0]  dec_a3;
  logic [31:0] dec_wd;
  logic [31:0] byte_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] link;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        unused_ok;

  assign op      = W_IR[31:26];
  assign funct   = W_IR[5:0];
  assign link    = W_PC + 32'd8;
  assign byte_sh = W_DR >> {W_Y[1:0], 3'b000};
  assign ld_byte = byte_sh[7:0];
  // W_Y[0] is deliberately ignored for halfwords: no misalignment trap.
  assign ld_half = W_Y[1] ? W_DR[31:16] : W_DR[15:0];
  assign unused_ok = &{1'b0, W_IR[25:21], W_IR[10:6]};

  always_comb begin
    dec_wr = 1'b0;
    dec_a3 = 5'd0;
    dec_wd = 32'd0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001, 6'b100011, 6'b000000: begin
            dec_wr = 1'b1; dec_a3 = W_IR[15:11]; dec_wd = W_Y;
          end
          6'b001001: begin
            dec_wr = 1'b1; dec_a3 = W_IR[15:11]; dec_wd = link;
          end
          default: ;
        endcase
      end
      6'b001101, 6'b001111: begin
        dec_wr = 1'b1; dec_a3 = W_IR[20:16]; dec_wd = W_Y;
      end
      6'b100011: begin
        dec_wr = 1'b1; dec_a3 = W_IR[20:16]; dec_wd = W_DR;
      end
      6'b100000: begin
        dec_wr = 1'b1; dec_a3 = W_IR[20:16]; dec_wd = {{24{ld_byte[7]}}, ld_byte};
      end
      6'b100100: begin
        dec_wr = 1'b1; dec_a3 = W_IR[20:16]; dec_wd = {24'd0, ld_byte};
      end
      6'b100001: begin
        dec_wr = 1'b1; dec_a3 = W_IR[20:16]; dec_wd = {{16{ld_half[15]}}, ld_half};
      end
      6'b100101: begin
        dec_wr = 1'b1; dec_a3 = W_IR[20:16]; dec_wd = {16'd0, ld_half};
      end
      6'b000011: begin
        dec_wr = 1'b1; dec_a3 = 5'd31; dec_wd = link;
      end
      default: ;
    endcase
  end

  assign W_WE = dec_wr && (dec_a3 != 5'd0) && !Rst;
  assign W_A3 = W_WE ? dec_a3 : 5'd0;
  assign W_WD = dec_wd;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (W_WE) begin
      regs[W_A3] <= W_WD;
    end
  end

  // Bypass is implicitly off during reset because W_WE is forced low.
  always_comb begin
    RD1 = regs[A1];
    RD2 = regs[A2];
    if (W_WE && (A1 == W_A3)) RD1 = W_WD;
    if (W_WE && (A2 == W_A3)) RD2 = W_WD;
    if (A1 == 5'd0) RD1 = 32'd0;
    if (A2 == 5'd0) RD2 = 32'd0;
  end

endmodule

// File: tb/tb_w_writeback_grf.sv
// tb/tb_w_writeback_grf.sv - scoreboard bench for w_writeback_grf.
module tb_w_writeback_grf;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] W_IR, W_PC, W_DR, W_Y;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2, W_WD;
  logic [4:0]  W_A3;
  logic        W_WE;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  localparam int K_RD1 = 0, K_RD2 = 1, K_WE = 2, K_A3 = 3, K_WD = 4;
  localparam logic [31:0] NOP = 32'd0;

  w_writeback_grf dut (
    .Clk(Clk), .Rst(Rst), .W_IR(W_IR), .W_PC(W_PC), .W_DR(W_DR), .W_Y(W_Y),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .W_A3(W_A3), .W_WD(W_WD), .W_WE(W_WE)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      K_RD1: return "rd1";
      K_RD2: return "rd2";
      K_WE:  return "we";
      K_A3:  return "a3";
      default: return "wd";
    endcase
  endfunction

  task automatic push(input int k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [31:0] ir, input logic [31:0] pc,
                       input logic [31:0] dr, input logic [31:0] y,
                       input logic [4:0] a1, input logic [4:0] a2);
    Rst = rst; W_IR = ir; W_PC = pc; W_DR = dr; W_Y = y; A1 = a1; A2 = a2;
  endtask

  // Compare everything queued for this cycle, then advance past the edge.
  task automatic cycle();
    exp_t e;
    logic [31:0] obs;
    #3;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD1: obs = RD1;
        K_RD2: obs = RD2;
        K_WE:  obs = {31'd0, W_WE};
        K_A3:  obs = {27'd0, W_A3};
        default: obs = W_WD;
      endcase
      check(kname(e.kind), obs, e.val);
    end
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd0, rt, 16'h0010};
  endfunction

  initial begin
    // power-up reset: write suppressed even for a valid ori
    drive(1'b1, i_type(6'b001101, 5'd5), 32'd0, 32'd0, 32'h1234, 5'd5, 5'd0);
    push(K_WE, 0); push(K_A3, 0);
    cycle();
    push(K_RD1, 0);
    cycle();

    // preload $5, bypass then stored
    drive(1'b0, i_type(6'b001101, 5'd5), 32'd0, 32'd0, 32'h1234, 5'd5, 5'd5);
    push(K_WE, 1); push(K_A3, 5); push(K_WD, 32'h1234); push(K_RD1, 32'h1234); push(K_RD2, 32'h1234);
    cycle();
    drive(1'b0, NOP, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
    push(K_WE, 0); push(K_RD1, 32'h1234);
    cycle();

    // reset mid-stream discards this cycle's write and clears the file
    drive(1'b1, i_type(6'b001101, 5'd5), 32'd0, 32'd0, 32'h5555, 5'd5, 5'd5);
    push(K_WE, 0); push(K_A3, 0); push(K_RD1, 32'h1234);
    cycle();
    drive(1'b0, NOP, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
    push(K_RD1, 0);
    cycle();

    // addu $8 with bypass on both ports
    drive(1'b0, r_type(5'd8, 6'b100001), 32'd0, 32'd0, 32'hDEADBEEF, 5'd8, 5'd8);
    push(K_WE, 1); push(K_A3, 8); push(K_RD1, 32'hDEADBEEF); push(K_RD2, 32'hDEADBEEF);
    cycle();
    drive(1'b0, NOP, 32'd0, 32'd0, 32'd0, 5'd8, 5'd0);
    push(K_RD1, 32'hDEADBEEF);
    cycle();

    // subu and lui
    drive(1'b0, r_type(5'd16, 6'b100011), 32'd0, 32'd0, 32'h00000001, 5'd16, 5'd8);
    push(K_A3, 16); push(K_RD1, 1); push(K_RD2, 32'hDEADBEEF);
    cycle();
    drive(1'b0, i_type(6'b001111, 5'd15), 32'd0, 32'd0, 32'hABCD0000, 5'd15, 5'd16);
    push(K_A3, 15); push(K_RD1, 32'hABCD0000); push(K_RD2, 1);
    cycle();

    // $0 protection
    drive(1'b0, {6'b001101, 5'd0, 5'd0, 16'hFFFF}, 32'd0, 32'd0, 32'h0000FFFF, 5'd0, 5'd0);
    push(K_WE, 0); push(K_A3, 0); push(K_RD1, 0); push(K_RD2, 0);
    cycle();
    drive(1'b0, NOP, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    push(K_RD1, 0);
    cycle();

    // sub-word loads
    drive(1'b0, i_type(6'b100000, 5'd9), 32'd0, 32'h80F17F01, 32'h00000103, 5'd9, 5'd0);
    push(K_WD, 32'hFFFFFF80); push(K_RD1, 32'hFFFFFF80);
    cycle();
    drive(1'b0, i_type(6'b100100, 5'd10), 32'd0, 32'h80F17F01, 32'h00000003, 5'd10, 5'd9);
    push(K_WD, 32'h00000080); push(K_RD2, 32'hFFFFFF80);
    cycle();
    drive(1'b0, i_type(6'b100001, 5'd11), 32'd0, 32'h80F17F01, 32'h00000000, 5'd11, 5'd10);
    push(K_WD, 32'h00007F01); push(K_RD2, 32'h00000080);
    cycle();
    drive(1'b0, i_type(6'b100101, 5'd12), 32'd0, 32'h80F17F01, 32'h00000002, 5'd12, 5'd11);
    push(K_WD, 32'h000080F1); push(K_RD2, 32'h00007F01);
    cycle();
    drive(1'b0, i_type(6'b100000, 5'd13), 32'd0, 32'h80F17F01, 32'h00000002, 5'd13, 5'd12);
    push(K_WD, 32'hFFFFFFF1); push(K_RD2, 32'h000080F1);
    cycle();
    drive(1'b0, i_type(6'b100001, 5'd14), 32'd0, 32'h80F17F01, 32'h00000001, 5'd14, 5'd13);
    push(K_WD, 32'h00007F01); push(K_RD2, 32'hFFFFFFF1);
    cycle();
    drive(1'b0, i_type(6'b100011, 5'd17), 32'd0, 32'h80F17F01, 32'h00000004, 5'd17, 5'd14);
    push(K_WD, 32'h80F17F01); push(K_RD2, 32'h00007F01);
    cycle();

    // link writes
    drive(1'b0, {6'b000011, 26'h0000C00}, 32'h00003000, 32'd0, 32'd0, 5'd31, 5'd0);
    push(K_WE, 1); push(K_A3, 31); push(K_WD, 32'h00003008);
    cycle();
    drive(1'b0, {6'b000000, 5'd3, 5'd0, 5'd4, 5'd0, 6'b001001}, 32'hFFFFFFFC, 32'd0, 32'd0, 5'd31, 5'd4);
    push(K_A3, 4); push(K_WD, 32'h00000004); push(K_RD1, 32'h00003008); push(K_RD2, 32'h00000004);
    cycle();

    // no-write instructions leave state untouched
    drive(1'b0, {6'b101011, 5'd0, 5'd8, 16'h0004}, 32'd0, 32'd0, 32'h4, 5'd8, 5'd31);
    push(K_WE, 0); push(K_A3, 0); push(K_WD, 0); push(K_RD1, 32'hDEADBEEF);
    cycle();
    drive(1'b0, {6'b000100, 5'd8, 5'd8, 16'h0001}, 32'd0, 32'd0, 32'd0, 5'd4, 5'd31);
    push(K_WE, 0); push(K_A3, 0); push(K_RD1, 4);
    cycle();
    drive(1'b0, {6'b000000, 5'd31, 15'd0, 6'b001000}, 32'h100, 32'd0, 32'd0, 5'd31, 5'd9);
    push(K_WE, 0); push(K_A3, 0); push(K_WD, 0); push(K_RD1, 32'h00003008);
    cycle();
    drive(1'b0, {6'b111111, 5'd1, 5'd8, 16'hFFFF}, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 5'd31);
    push(K_WE, 0); push(K_A3, 0); push(K_WD, 0);
    cycle();
    drive(1'b0, NOP, 32'd0, 32'd0, 32'd0, 5'd8, 5'd31);
    push(K_RD1, 32'hDEADBEEF); push(K_RD2, 32'h00003008);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/w_writeback_grf.md
# w_writeback_grf

Writeback stage and general register file for the five-stage pipeline. It consumes the W-stage pipeline register outputs (instruction, PC, memory read data and ALU result), decodes the destination register, and forms the final write data, including sub-word load extraction and link address. It then commits the result into a 32×32 register file on the clock edge. It also provides the D-stage read ports with write-through bypass, and exports the W-stage write triple to the hazard/forwarding logic.

## Interface
Parameters: none.

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- W_IR  in  32  instruction in W stage
- W_PC  in  32  PC of that instruction
- W_DR  in  32  raw word read from data memory (word-aligned)
- W_Y  in  32  ALU result / memory address
- A1  in  5  read address, port 1 (D stage rs)
- A2  in  5  read address, port 2 (D stage rt)
- RD1  out  32  read data, port 1
- RD2  out  32  read data, port 2
- W_A3  out  5  decoded destination register (0 when no write)
- W_WD  out  32  decoded write data
- W_WE  out  1  write enable actually applied this cycle

## Operation
- Register file: 32 × 32-bit registers. $0 always reads 0 and is never written.
- Decode of destination and write source from W_IR (op = [31:26], funct = [5:0]):
  - op 000000, funct 100001/100011 (addu/subu), 000000 (sll): A3 = IR[15:11], WD = W_Y.
  - op 000000, funct 001001 (jalr): A3 = IR[15:11], WD = W_PC + 8.
  - op 001101 (ori), 001111 (lui): A3 = IR[20:16], WD = W_Y.
  - op 100011 (lw): A3 = rt, WD = W_DR.
  - op 100000/100100 (lb/lbu): A3 = rt, WD = byte W_DR[8·W_Y[1:0] +: 8], sign-/zero-extended.
  - op 100001/100101 (lh/lhu): A3 = rt, WD = halfword W_DR[16·W_Y[1] +: 16], sign-/zero-extended. W_Y[0] is ignored; there is no misalignment trap.
  - op 000011 (jal): A3 = 31, WD = W_PC + 8.
  - All others (sw, beq, j, jr, undefined): no write, A3 = 0, WD = 0.
- W_WE = decoded-write AND (A3 ≠ 0) AND NOT Rst. W_A3 = 0 whenever W_WE = 0.
- A nop (all-zero IR) decodes as sll $0, so it produces W_WE = 0.
- Read ports, combinational:
  - RDn = 0 if An = 0.
  - Otherwise RDn = W_WD if W_WE and An = W_A3 (write-through bypass).
  - Otherwise RDn = stored register.
- W_PC + 8 is a 32-bit wrap-around add.

## Timing
- Write commits at the rising Clk edge when W_WE = 1. The value is visible from the stored array in the following cycle, and through the bypass in the same cycle.
- Reset: at a rising edge with Rst = 1, all 32 registers clear to 0. Reset has priority over any write in the same cycle.
- While Rst = 1: W_WE = 0, W_A3 = 0, bypass disabled, and RD1/RD2 return stored values (0 after the first reset edge).
- Reset asserted mid-stream discards the W-stage write of that cycle. Operation resumes on the first edge after Rst deasserts.
- Both read ports may address the same register, or the register being written, simultaneously. Both ports return the bypassed value.
- Combinational path: W_IR/W_DR/W_Y → RD1/RD2 (decode + extract + bypass mux). No added latency.

## Test plan
- Reset: preload $5 = 0x1234 via ori, assert Rst for 1 cycle. Then RD1 at A1 = 5 must read 0x00000000 and W_WE must be 0 during Rst.
- ALU writeback and bypass: W_IR = addu $8,$1,$2, W_Y = 0xDEADBEEF, A1 = 8.
  - Same cycle: RD1 = 0xDEADBEEF.
  - Next cycle, with W_IR = nop: RD1 still reads 0xDEADBEEF.
- $0 protection: W_IR = ori $0,$0,0xFFFF, W_Y = 0xFFFF. Required: W_WE = 0, and RD1 at A1 = 0 reads 0 in both that cycle and the next.
- Sub-word loads: W_DR = 0x80F17F01.
  - lb with W_Y[1:0] = 3 → 0xFFFFFF80.
  - lbu with W_Y[1:0] = 3 → 0x00000080.
  - lh with W_Y[1] = 0 → 0x00007F01.
  - lhu with W_Y[1] = 1 → 0x000080F1.
  - lb with W_Y[1:0] = 2 → 0xFFFFFFF1.
- Link: jal with W_PC = 0x00003000 writes $31 = 0x00003008. jalr $4 with W_PC = 0xFFFFFFFC writes $4 = 0x00000004 (wrap).
- No-write instructions: sw, beq, jr and op 111111 each leave W_WE = 0 and W_A3 = 0, and all registers unchanged.
